display_shift_driver: RTL and testbench

//  Serialises the clock's BCD display digits into 7-segment patterns and shifts them
//  out to an external daisy-chain of 74HC595-style shift registers.

---
 rtl/display_shift_driver.sv | 137 +++++++++++++
 tb/tb_display_shift_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/display_shift_driver.sv
// Shifts 7-segment encoded BCD digits out to a 74HC595-style daisy chain, one frame per refresh.
// Optional build macro COMMON_ANODE_EN inverts every encoded bit (segments and dp).
module display_shift_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    refresh,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    blank_lead,
    output logic                    serial_out,
    output logic                    clk_out,
    output logic                    latch_out,
    output logic                    busy
);

    localparam int NBITS = 8 * NUM_DIGITS;
    localparam int CW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW    = $clog2(NBITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t             state;
    logic [NBITS-1:0]   sr;
    logic [NBITS-1:0]   frame;
    logic [CW-1:0]      cnt;
    logic [BW-1:0]      bitcnt;
    logic               pending;
    logic               phase_end;
    logic               start;

    function automatic logic [7:0] encode(input logic [3:0] code, input logic point,
                                          input logic blank);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        if (blank)
            seg = '0;
`ifdef COMMON_ANODE_EN
        encode = ~{point, seg};
`else
        encode = {point, seg};
`endif
    endfunction

    // Digit 0 occupies the top byte so a plain MSB-first shift sends it first.
    always_comb begin
        frame = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            frame[NBITS-8-8*i +: 8] = encode(digits[4*i +: 4], dp[i],
                                             blank_lead && (i == unsigned'(NUM_DIGITS - 1)) &&
                                             (digits[4*i +: 4] == 4'd0));
        end
    end

    assign phase_end = (cnt == CNT_LAST);
    assign start     = ((state == IDLE) && refresh) ||
                       ((state == LATCH) && phase_end && (pending || refresh));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            bitcnt     <= '0;
            pending    <= 1'b0;
            serial_out <= 1'b0;
            clk_out    <= 1'b0;
            latch_out  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (state != IDLE && refresh)
                pending <= 1'b1;
            cnt <= (state == IDLE || phase_end) ? '0 : cnt + 1'b1;

            case (state)
                SHIFT_LO: begin
                    if (phase_end) begin
                        clk_out <= 1'b1;
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_end) begin
                        clk_out <= 1'b0;
                        if (bitcnt == BIT_LAST) begin
                            serial_out <= 1'b0;
                            latch_out  <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            sr         <= {sr[NBITS-2:0], 1'b0};
                            serial_out <= sr[NBITS-2];
                            bitcnt     <= bitcnt + 1'b1;
                            state      <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (phase_end) begin
                        latch_out <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: ;
            endcase

            // A new frame (from idle or straight out of LATCH) overrides the updates above.
            if (start) begin
                sr         <= frame;
                serial_out <= frame[NBITS-1];
                clk_out    <= 1'b0;
                latch_out  <= 1'b0;
                busy       <= 1'b1;
                bitcnt     <= '0;
                pending    <= 1'b0;
                state      <= SHIFT_LO;
            end
        end
    end

endmodule

// File: tb/tb_display_shift_driver.sv
// Bench for display_shift_driver: CLK_DIV=1 and CLK_DIV=3 instances share stimulus and are
// checked per cycle against a frame-position model, plus a frame scoreboard on latch pulses.
module tb_display_shift_driver;

    logic        clk = 1'b0;
    logic        reset, refresh, blank_lead;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [1:0]  ser, ck, la, bz;

    always #5 clk = ~clk;

    display_shift_driver #(.NUM_DIGITS(4), .CLK_DIV(1)) u_dut0 (
        .clk(clk), .reset(reset), .refresh(refresh), .digits(digits), .dp(dp),
        .blank_lead(blank_lead), .serial_out(ser[0]), .clk_out(ck[0]),
        .latch_out(la[0]), .busy(bz[0])
    );

    display_shift_driver #(.NUM_DIGITS(4), .CLK_DIV(3)) u_dut1 (
        .clk(clk), .reset(reset), .refresh(refresh), .digits(digits), .dp(dp),
        .blank_lead(blank_lead), .serial_out(ser[1]), .clk_out(ck[1]),
        .latch_out(la[1]), .busy(bz[1])
    );

    int          nvec = 0;
    int          nerr = 0;
    int          rem[2]  = '{0, 0};
    int          pend[2] = '{0, 0};
    int          dv[2]   = '{1, 3};
    int          lenv[2] = '{65, 195};
    logic [31:0] fr[2];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          epoch = 0;
    logic [7:0]  seg_tab[10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    function automatic logic [31:0] ref_frame(input logic [15:0] d, input logic [3:0] p,
                                              input logic bl);
        logic [31:0] f;
        logic [7:0]  b;
        logic [3:0]  c;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            c = d[4*i +: 4];
            b = (c < 4'd10) ? seg_tab[c] : 8'h00;
            if (bl && i == 3 && c == 4'd0)
                b = 8'h00;
            b[7] = p[i];
`ifdef COMMON_ANODE_EN
            b = ~b;
`endif
            f[31-8*i -: 8] = b;
        end
        return f;
    endfunction

    task automatic check(input string name, input int k, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[dut%0d] t=%0t got %b want %b", name, k, $time, act, exp);
        end
    endtask

    task automatic start_frame(input int k);
        fr[k]   = ref_frame(digits, dp, blank_lead);
        rem[k]  = lenv[k];
        pend[k] = 0;
        if (k == 0) q0.push_back(fr[k]);
        else        q1.push_back(fr[k]);
    endtask

    // One clock: apply the edge to the model, then compare every pin mid-cycle.
    task automatic cycle();
        int p, d, b;
        logic e_ser, e_ck, e_la, e_bz;
        @(posedge clk);
        if (reset) epoch++;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                rem[k] = 0; pend[k] = 0;
                if (k == 0) q0.delete(); else q1.delete();
            end else if (rem[k] == 0) begin
                if (refresh) start_frame(k);
            end else if (rem[k] == 1) begin
                if (pend[k] != 0 || refresh) start_frame(k);
                else rem[k] = 0;
            end else begin
                rem[k]--;
                if (refresh) pend[k] = 1;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e_ser = 1'b0; e_ck = 1'b0; e_la = 1'b0; e_bz = 1'b0;
            if (rem[k] != 0) begin
                d = dv[k];
                p = lenv[k] - rem[k];
                e_bz = 1'b1;
                if (p < 64 * d) begin
                    b     = p / (2 * d);
                    e_ck  = ((p % (2 * d)) >= d);
                    e_ser = fr[k][31 - b];
                end else begin
                    e_la = 1'b1;
                end
            end
            check("serial_out", k, ser[k], e_ser);
            check("clk_out", k, ck[k], e_ck);
            check("latch_out", k, la[k], e_la);
            check("busy", k, bz[k], e_bz);
        end
    endtask

    // Frame scoreboard: collect bits on clk_out rises, compare on each latch rise.
    logic [1:0]  pck = '0;
    logic [1:0]  pla = '0;
    logic [31:0] mbits[2];
    int          mn[2]  = '{0, 0};
    int          mep[2] = '{0, 0};

    always @(negedge clk) begin
        logic [31:0] exp_f;
        logic        have;
        for (int k = 0; k < 2; k++) begin
            if (mep[k] != epoch) begin
                mep[k] = epoch;
                mn[k]  = 0;
            end
            if (ck[k] && !pck[k]) begin
                mbits[k] = {mbits[k][30:0], ser[k]};
                mn[k]++;
            end
            if (la[k] && !pla[k]) begin
                have  = 1'b0;
                exp_f = '0;
                if (k == 0 && q0.size() > 0) begin exp_f = q0.pop_front(); have = 1'b1; end
                if (k == 1 && q1.size() > 0) begin exp_f = q1.pop_front(); have = 1'b1; end
                nvec++;
                if (!have) begin
                    nerr++;
                    $display("FAIL frame[dut%0d] t=%0t unexpected latch, got %h", k, $time, mbits[k]);
                end else if (mn[k] != 32 || mbits[k] !== exp_f) begin
                    nerr++;
                    $display("FAIL frame[dut%0d] t=%0t got %h (%0d rises) want %h (32 rises)",
                             k, $time, mbits[k], mn[k], exp_f);
                end
                mn[k] = 0;
            end
            pck[k] = ck[k];
            pla[k] = la[k];
        end
    end

    task automatic pulse_refresh();
        refresh = 1'b1;
        cycle();
        refresh = 1'b0;
    endtask

    task automatic run_idle();
        for (int n = 0; n < 2000 && (rem[0] != 0 || rem[1] != 0); n++)
            cycle();
        cycle();
        cycle();
    endtask

    task automatic frame(input logic [15:0] d, input logic [3:0] p, input logic bl);
        digits = d; dp = p; blank_lead = bl;
        pulse_refresh();
        run_idle();
    endtask

    initial begin
        reset = 1'b1; refresh = 1'b0; digits = '0; dp = '0; blank_lead = 1'b0;
        @(negedge clk);
        repeat (3) cycle();
        reset = 1'b0;
        cycle();

        frame(16'h1234, 4'b0000, 1'b0);
        frame(16'h0930, 4'b0000, 1'b1);
        frame(16'h0930, 4'b0000, 1'b0);
        frame(16'h0930, 4'b0100, 1'b1);
        frame(16'hFA00, 4'b0000, 1'b0);
        frame(16'h0000, 4'b1111, 1'b1);

        // Back-to-back: extra refreshes at cycles 10 and 20, new digits at cycle 30.
        digits = 16'h5678; dp = 4'b0001; blank_lead = 1'b0;
        pulse_refresh();
        repeat (9) cycle();
        pulse_refresh();
        repeat (9) cycle();
        pulse_refresh();
        repeat (9) cycle();
        digits = 16'h9012;
        run_idle();

        // Refresh landing on the edge that ends LATCH of the fast instance.
        digits = 16'h3456; dp = 4'b0000;
        pulse_refresh();
        for (int n = 0; n < 200 && rem[0] != 1; n++) cycle();
        digits = 16'h7801;
        pulse_refresh();
        run_idle();

        // Reset mid-frame, then a clean frame.
        digits = 16'h2468;
        pulse_refresh();
        repeat (29) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        repeat (3) cycle();
        frame(16'h1357, 4'b1010, 1'b1);

        for (int n = 0; n < 4000; n++) begin
            refresh = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0) begin
                digits     = 16'($urandom);
                dp         = 4'($urandom);
                blank_lead = 1'($urandom);
            end
            if ($urandom_range(0, 9) == 0)
                digits[15:12] = 4'd0;
            reset = ($urandom_range(0, 699) == 0);
            cycle();
        end
        refresh = 1'b0;
        reset   = 1'b0;
        run_idle();

        nvec++;
        if (q0.size() != 0 || q1.size() != 0) begin
            nerr++;
            $display("FAIL undelivered_frames got %0d/%0d want 0/0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
